spi_flash_rcache: RTL and testbench

Direct-mapped, one-word-per-line read cache and request sequencer that sits between the CPU data/instruction read port and the memory-mapped SPI flash reader. It serves repeated reads of flash words in one cycle. On a miss it issues a single read strobe to the flash reader, tracks that reader's busy window, and refills the line. It is the only client of the flash reader's `rstrb` / `word_address` / `rdata` / `rbusy` port.

---
 rtl/spi_flash_rcache_if.sv | 46 ++++
 rtl/spi_flash_rcache.sv | 166 ++++++++++++++++
 tb/tb_spi_flash_rcache.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_rcache_if.sv
// CPU-side and flash-side bundles for spi_flash_rcache.
// The cache is the slave of the CPU bundle and the master of the flash bundle.
interface spi_flash_rcache_cpu_if;
  logic        cpu_rstrb;
  logic [19:0] cpu_word_address;
  logic [31:0] cpu_rdata;
  logic        cpu_rbusy;
  logic        cache_flush;

  modport master (
    output cpu_rstrb,
    output cpu_word_address,
    output cache_flush,
    input  cpu_rdata,
    input  cpu_rbusy
  );

  modport slave (
    input  cpu_rstrb,
    input  cpu_word_address,
    input  cache_flush,
    output cpu_rdata,
    output cpu_rbusy
  );
endinterface

interface spi_flash_rcache_flash_if;
  logic        flash_rstrb;
  logic [19:0] flash_word_address;
  logic [31:0] flash_rdata;
  logic        flash_rbusy;

  modport master (
    output flash_rstrb,
    output flash_word_address,
    input  flash_rdata,
    input  flash_rbusy
  );

  modport slave (
    input  flash_rstrb,
    input  flash_word_address,
    output flash_rdata,
    output flash_rbusy
  );
endinterface

// File: rtl/spi_flash_rcache.sv
// Direct-mapped one-word-per-line read cache and miss sequencer in front of the SPI flash reader.
// Tag/data/valid storage is built only when SPI_FLASH_RCACHE_EN is defined; otherwise every request misses.
module spi_flash_rcache #(
  parameter int INDEX_BITS = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  spi_flash_rcache_cpu_if.slave           cpu,
  spi_flash_rcache_flash_if.master        flash
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 20 - INDEX_BITS;

  localparam logic [2:0] ST_DRAIN = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_ARM   = 3'd3;
  localparam logic [2:0] ST_FILL  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_rbusy_q, cpu_rbusy_d;
  logic        flash_rstrb_q, flash_rstrb_d;
  logic [19:0] flash_addr_q, flash_addr_d;

  logic        hit_s;
  logic [31:0] hit_data_s;
  logic        fill_done_s;

  assign fill_done_s = (state_q == ST_FILL) && !flash.flash_rbusy;

`ifdef SPI_FLASH_RCACHE_EN
  logic [INDEX_BITS-1:0] req_idx_s;
  logic [INDEX_BITS-1:0] fill_idx_s;
  logic [TAG_W-1:0]      req_tag_s;
  logic [TAG_W-1:0]      fill_tag_s;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [31:0]           data_q [LINES];
  logic                  flush_pend_q, flush_pend_d;

  assign req_idx_s  = cpu.cpu_word_address[INDEX_BITS-1:0];
  assign req_tag_s  = cpu.cpu_word_address[19:INDEX_BITS];
  assign fill_idx_s = flash_addr_q[INDEX_BITS-1:0];
  assign fill_tag_s = flash_addr_q[19:INDEX_BITS];

  // Lookup reads the pre-flush contents, so a hit coinciding with a flush is still served.
  assign hit_s      = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
  assign hit_data_s = data_q[req_idx_s];

  // Valid bits and the "flushed while a miss was outstanding" marker.
  always_comb begin
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    if ((state_q == ST_IDLE) || (state_q == ST_DRAIN)) begin
      flush_pend_d = 1'b0;
    end else begin
      flush_pend_d = flush_pend_q | cpu.cache_flush;
    end
    if (cpu.cache_flush) begin
      valid_d = {LINES{1'b0}};
    end else if (fill_done_s && !flush_pend_q) begin
      valid_d[fill_idx_s] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid/flush-marker registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q      <= {LINES{1'b0}};
      flush_pend_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Tag and data arrays need no reset: nothing is read while its valid bit is clear.
  always_ff @(posedge clk) begin
    if (fill_done_s) begin
      tag_q[fill_idx_s]  <= fill_tag_s;
      data_q[fill_idx_s] <= flash.flash_rdata;
    end
  end
`else
  assign hit_s      = 1'b0;
  assign hit_data_s = 32'd0;
`endif

  // Miss sequencer: DRAIN -> IDLE, and IDLE -> ISSUE -> ARM -> FILL -> IDLE per miss.
  always_comb begin
    state_d      = state_q;
    cpu_rdata_d  = cpu_rdata_q;
    flash_addr_d = flash_addr_q;
    case (state_q)
      ST_DRAIN: begin
        if (!flash.flash_rbusy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_IDLE: begin
        if (cpu.cpu_rstrb) begin
          if (hit_s) begin
            cpu_rdata_d = hit_data_s;
          end else begin
            flash_addr_d = cpu.cpu_word_address;
            state_d      = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_ARM;
      end
      ST_ARM: begin
        if (flash.flash_rbusy) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_FILL: begin
        if (!flash.flash_rbusy) begin
          cpu_rdata_d = flash.flash_rdata;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_DRAIN;
      end
    endcase
    cpu_rbusy_d   = (state_d == ST_ISSUE) || (state_d == ST_ARM) || (state_d == ST_FILL);
    flash_rstrb_d = (state_d == ST_ISSUE);
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_DRAIN;
      cpu_rdata_q   <= 32'd0;
      cpu_rbusy_q   <= 1'b0;
      flash_rstrb_q <= 1'b0;
      flash_addr_q  <= 20'd0;
    end else begin
      state_q       <= state_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_rbusy_q   <= cpu_rbusy_d;
      flash_rstrb_q <= flash_rstrb_d;
      flash_addr_q  <= flash_addr_d;
    end
  end

  assign cpu.cpu_rdata          = cpu_rdata_q;
  assign cpu.cpu_rbusy          = cpu_rbusy_q;
  assign flash.flash_rstrb      = flash_rstrb_q;
  assign flash.flash_word_address = flash_addr_q;

endmodule

// File: tb/tb_spi_flash_rcache.sv
// Self-checking bench for spi_flash_rcache: flash reader model, transaction-level cache model
// compared every cycle, plus literal expectations for data words and strobe counts.
module tb_spi_flash_rcache;

  localparam int BUSY_LEN = 6;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  spi_flash_rcache_cpu_if   cpu_bus ();
  spi_flash_rcache_flash_if flash_bus ();

  spi_flash_rcache #(.INDEX_BITS(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .cpu    (cpu_bus),
    .flash  (flash_bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int strobe_cnt = 0;

  // Content of flash word a, as returned by the reader model.
  function automatic logic [31:0] flash_word(input logic [19:0] a);
    return {a[11:0], a} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Cache model: 16 lines, index = addr mod 16, tag = addr div 16.
  bit          m_valid [16];
  int          m_tag   [16];
  logic [31:0] m_data  [16];
  bit          m_drain, m_busy, m_seen, m_flushed;
  int          m_cnt;
  logic [31:0] m_rdata;
  logic [19:0] m_addr;

  function automatic bit model_hit(input logic [19:0] a);
`ifdef SPI_FLASH_RCACHE_EN
    return m_valid[int'(a) % 16] && (m_tag[int'(a) % 16] == int'(a) / 16);
`else
    return 1'b0;
`endif
  endfunction

  // Flash reader: busy during/after reset, then one fixed-length transfer per strobe.
  initial begin
    flash_bus.flash_rbusy = 1'b1;
    flash_bus.flash_rdata = 32'd0;
    @(posedge resetn);
    repeat (10) @(negedge clk);
    flash_bus.flash_rbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (flash_bus.flash_rstrb) begin
        flash_bus.flash_rbusy = 1'b1;
        repeat (BUSY_LEN) @(negedge clk);
        flash_bus.flash_rdata = flash_word(flash_bus.flash_word_address);
        flash_bus.flash_rbusy = 1'b0;
      end
    end
  end

  // Model update at each edge, then compare all outputs just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!resetn) begin
        m_drain = 1'b1; m_busy = 1'b0; m_seen = 1'b0; m_flushed = 1'b0;
        m_cnt = 0; m_rdata = 32'd0; m_addr = 20'd0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      end else begin
        if (m_drain) begin
          if (!flash_bus.flash_rbusy) m_drain = 1'b0;
        end else if (!m_busy) begin
          if (cpu_bus.cpu_rstrb) begin
            if (model_hit(cpu_bus.cpu_word_address)) begin
              m_rdata = m_data[int'(cpu_bus.cpu_word_address) % 16];
            end else begin
              m_busy = 1'b1; m_cnt = 0; m_seen = 1'b0; m_flushed = 1'b0;
              m_addr = cpu_bus.cpu_word_address;
            end
          end
        end else begin
          m_cnt++;
          if (cpu_bus.cache_flush) m_flushed = 1'b1;
          if (m_cnt >= 2) begin
            if (!m_seen) begin
              m_seen = flash_bus.flash_rbusy;
            end else if (!flash_bus.flash_rbusy) begin
              m_busy  = 1'b0;
              m_rdata = flash_word(m_addr);
              if (!m_flushed) begin
                m_valid[int'(m_addr) % 16] = 1'b1;
                m_tag[int'(m_addr) % 16]   = int'(m_addr) / 16;
                m_data[int'(m_addr) % 16]  = flash_word(m_addr);
              end
            end
          end
        end
        if (cpu_bus.cache_flush)
          for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      end
      #1;
      if (flash_bus.flash_rstrb) strobe_cnt++;
      chk("cpu_rbusy",   {31'd0, cpu_bus.cpu_rbusy},     {31'd0, m_busy});
      chk("cpu_rdata",   cpu_bus.cpu_rdata,              m_rdata);
      chk("flash_addr",  {12'd0, flash_bus.flash_word_address}, {12'd0, m_addr});
      chk("flash_rstrb", {31'd0, flash_bus.flash_rstrb}, {31'd0, (m_busy && m_cnt == 0)});
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && cpu_bus.cpu_rbusy; i++) @(negedge clk);
    chk("idle_timeout", {31'd0, cpu_bus.cpu_rbusy}, 32'd0);
  endtask

  task automatic do_read(input logic [19:0] a);
    @(negedge clk);
    cpu_bus.cpu_rstrb        = 1'b1;
    cpu_bus.cpu_word_address = a;
    @(negedge clk);
    cpu_bus.cpu_rstrb = 1'b0;
    wait_idle();
  endtask

  initial begin
    resetn = 1'b0;
    cpu_bus.cpu_rstrb        = 1'b0;
    cpu_bus.cpu_word_address = 20'd0;
    cpu_bus.cache_flush      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rdata", cpu_bus.cpu_rdata, 32'd0);
    resetn = 1'b1;
    repeat (14) @(negedge clk);
    chk("drain_no_strobe", strobe_cnt, 32'd0);

    do_read(20'h00010);
    chk("miss_0x10_data", cpu_bus.cpu_rdata, 32'h5B5A_0010);
    chk("miss_0x10_strobes", strobe_cnt, 32'd1);
    chk("miss_0x10_addr", {12'd0, flash_bus.flash_word_address}, 32'h0000_0010);

    // Repeat read: served from the cache in one cycle when enabled.
    @(negedge clk);
    cpu_bus.cpu_rstrb = 1'b1;
    cpu_bus.cpu_word_address = 20'h00010;
    @(negedge clk);
    cpu_bus.cpu_rstrb = 1'b0;
`ifdef SPI_FLASH_RCACHE_EN
    chk("hit_0x10_data", cpu_bus.cpu_rdata, 32'h5B5A_0010);
    chk("hit_0x10_busy", {31'd0, cpu_bus.cpu_rbusy}, 32'd0);
    chk("hit_0x10_strobes", strobe_cnt, 32'd1);
`else
    wait_idle();
    chk("reread_0x10_data", cpu_bus.cpu_rdata, 32'h5B5A_0010);
    chk("reread_0x10_strobes", strobe_cnt, 32'd2);
`endif

    do_read(20'h00020);
    chk("conflict_0x20_data", cpu_bus.cpu_rdata, 32'h585A_0020);
    do_read(20'h00010);
    chk("evicted_0x10_data", cpu_bus.cpu_rdata, 32'h5B5A_0010);
`ifdef SPI_FLASH_RCACHE_EN
    chk("conflict_strobes", strobe_cnt, 32'd3);
`else
    chk("conflict_strobes", strobe_cnt, 32'd4);
`endif

    // Request arriving during FILL must be ignored.
    @(negedge clk);
    cpu_bus.cpu_rstrb = 1'b1;
    cpu_bus.cpu_word_address = 20'h00041;
    @(negedge clk);
    cpu_bus.cpu_rstrb = 1'b0;
    repeat (3) @(negedge clk);
    cpu_bus.cpu_rstrb = 1'b1;
    cpu_bus.cpu_word_address = 20'h00033;
    @(negedge clk);
    cpu_bus.cpu_rstrb = 1'b0;
    chk("fill_ignore_addr", {12'd0, flash_bus.flash_word_address}, 32'h0000_0041);
    wait_idle();
    chk("fill_ignore_data", cpu_bus.cpu_rdata, 32'h5E4A_0041);

    // Flush during ARM: data still returned, line left invalid.
    @(negedge clk);
    cpu_bus.cpu_rstrb = 1'b1;
    cpu_bus.cpu_word_address = 20'h00005;
    @(negedge clk);
    cpu_bus.cpu_rstrb = 1'b0;
    @(negedge clk);
    cpu_bus.cache_flush = 1'b1;
    @(negedge clk);
    cpu_bus.cache_flush = 1'b0;
    wait_idle();
    chk("flush_arm_data", cpu_bus.cpu_rdata, 32'h5A0A_0005);
    do_read(20'h00005);
    chk("flush_reread_data", cpu_bus.cpu_rdata, 32'h5A0A_0005);
`ifdef SPI_FLASH_RCACHE_EN
    chk("total_strobes", strobe_cnt, 32'd6);
`else
    chk("total_strobes", strobe_cnt, 32'd7);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
